// File: rtl/ifft_frame_loader_if.sv
// Sample stream, frame handshake and memory write port of the IFFT frame loader.
interface ifft_frame_loader_if #(
    parameter int DW = 14,
    parameter int AW = 5
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [2*DW-1:0]   in_data;
    logic              in_last;
    logic              mem_write;
    logic [AW-1:0]     mem_waddr;
    logic [2*DW-1:0]   mem_wdata;
    logic              frame_ready;
    logic              frame_taken;
    logic              frame_err;
    logic [7:0]        frames_loaded;

    modport master (
        output flush, in_valid, in_data, in_last, frame_taken,
        input  in_ready, mem_write, mem_waddr, mem_wdata,
               frame_ready, frame_err, frames_loaded
    );

    modport slave (
        input  flush, in_valid, in_data, in_last, frame_taken,
        output in_ready, mem_write, mem_waddr, mem_wdata,
               frame_ready, frame_err, frames_loaded
    );
endinterface

// File: rtl/ifft_frame_loader.sv
// IFFT input stage: optionally conjugates samples and writes them (bit-reversed) into the frame memory.
// Latency: write strobe 1 cycle after accept, frame_ready 2 cycles after the final accept; in_ready low from frame end until frame_taken.
module ifft_frame_loader #(
    parameter int DW     = 14,
    parameter int AW     = 5,
    parameter bit BITREV = 1'b1,
    parameter bit CONJ   = 1'b1
) (
    input logic                clk,
    input logic                rst_n,
    ifft_frame_loader_if.slave bus
);
    localparam int SW = 2 * DW;
    localparam logic [DW-1:0] IM_MIN   = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] IM_MAX   = {1'b0, {(DW-1){1'b1}}};
    localparam logic [AW-1:0] LAST_IDX = {AW{1'b1}};

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_DRAIN = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  cnt_q, cnt_d;
    logic           rdy_en_q;
    logic           wr_q, wr_d;
    logic [AW-1:0]  waddr_q, waddr_d;
    logic [SW-1:0]  wdata_q, wdata_d;
    logic           ready_q, ready_d;
    logic           err_q, err_d;
    logic [7:0]     loaded_q, loaded_d;
    logic           accept;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        r = '0;
        for (int i = 0; i < AW; i++) begin
            r[i] = a[AW-1-i];
        end
        return r;
    endfunction

    // Negating the most negative imag value would overflow, so it clamps to the positive maximum.
    function automatic logic [SW-1:0] process_sample(input logic [SW-1:0] s);
        logic [DW-1:0] im;
        im = s[DW-1:0];
        if (CONJ) begin
            if (im == IM_MIN) begin
                im = IM_MAX;
            end else begin
                im = -im;
            end
        end
        return {s[SW-1:DW], im};
    endfunction

    // rdy_en_q keeps in_ready low until the first edge after reset release.
    assign bus.in_ready = rdy_en_q & (state_q == S_LOAD) & ~bus.flush;
    assign accept       = bus.in_valid & bus.in_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        ready_d  = ready_q;
        err_d    = err_q;
        loaded_d = loaded_q;

        if (bus.flush) begin
            state_d = S_LOAD;
            cnt_d   = '0;
            ready_d = 1'b0;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                S_LOAD: begin
                    if (accept) begin
                        wr_d    = 1'b1;
                        waddr_d = BITREV ? bitrev(cnt_q) : cnt_q;
                        wdata_d = process_sample(bus.in_data);
                        if (cnt_q == LAST_IDX) begin
                            state_d = S_DRAIN;
                            cnt_d   = '0;
                            if (!bus.in_last) begin
                                err_d = 1'b1;
                            end
                        end else if (bus.in_last) begin
                            // Early end of frame: the partial frame is dropped and indexing restarts.
                            err_d = 1'b1;
                            cnt_d = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    // Advertise the frame only once the final write strobe has retired into memory.
                    if (!wr_q) begin
                        state_d  = S_FULL;
                        ready_d  = 1'b1;
                        loaded_d = loaded_q + 8'd1;
                    end
                end
                S_FULL: begin
                    if (bus.frame_taken) begin
                        state_d = S_LOAD;
                        ready_d = 1'b0;
                    end
                end
                default: begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_LOAD;
            cnt_q    <= '0;
            rdy_en_q <= 1'b0;
            wr_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            loaded_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdy_en_q <= 1'b1;
            wr_q     <= wr_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
            loaded_q <= loaded_d;
        end
    end

    assign bus.mem_write     = wr_q;
    assign bus.mem_waddr     = waddr_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.frame_ready   = ready_q;
    assign bus.frame_err     = err_q;
    assign bus.frames_loaded = loaded_q;
endmodule

// File: tb/tb_ifft_frame_loader.sv
// Bench for ifft_frame_loader: vector table, directed framing corner cases and random frames against a queue model.
module tb_ifft_frame_loader;
    localparam int DW = 14;
    localparam int AW = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ifft_frame_loader_if #(.DW(DW), .AW(AW)) bus ();

    ifft_frame_loader #(.DW(DW), .AW(AW), .BITREV(1'b1), .CONJ(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [27:0] din;
        logic        last;
        logic [4:0]  addr;
        logic [27:0] dout;
    } vec_t;
    vec_t vecs [8];

    typedef struct {
        logic [4:0]  a;
        logic [27:0] d;
    } wr_t;
    wr_t exp_q [$];

    // Reference model state: index within frame, sticky error, completed frames.
    int m_idx    = 0;
    int m_err    = 0;
    int m_frames = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int rev_index(input int k);
        int r = 0;
        for (int i = 0; i < AW; i++) r = r * 2 + ((k >> i) & 1);
        return r;
    endfunction

    function automatic logic [27:0] model_conj(input logic [27:0] s);
        logic signed [13:0] ims;
        int im;
        logic [31:0] u;
        ims = s[13:0];
        im  = ims;
        im  = -im;
        if (im > 8191) im = 8191;
        u = im;
        return {s[27:14], u[13:0]};
    endfunction

    task automatic model_accept(input logic [27:0] d, input bit l);
        wr_t w;
        int r;
        r   = rev_index(m_idx);
        w.a = r[4:0];
        w.d = model_conj(d);
        exp_q.push_back(w);
        if (m_idx == 31) begin
            if (!l) m_err = 1;
            m_idx = 0;
            m_frames++;
        end else if (l) begin
            m_err = 1;
            m_idx = 0;
        end else begin
            m_idx++;
        end
    endtask

    // Called half a nanosecond-ish after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [27:0] d, input bit l);
        bit done = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (bus.in_ready) done = 1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (done) model_accept(d, l);
        else check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_frame();
        bit seen = 0;
        for (int t = 0; t < 8 && !seen; t++) begin
            @(negedge clk);
            if (bus.frame_ready) seen = 1;
        end
        check("frame_ready_wait", {31'd0, seen}, 32'd1);
    endtask

    task automatic take();
        @(posedge clk);
        #1 bus.frame_taken = 1'b1;
        @(posedge clk);
        #1 bus.frame_taken = 1'b0;
    endtask

    task automatic pulse_flush();
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 28'h5555555;
        #1 check("flush_blocks_ready", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        m_idx = 0;
        m_err = 0;
        @(negedge clk);
        check("flush_no_write", {31'd0, bus.mem_write}, 32'd0);
        check("flush_ready_clr", {31'd0, bus.frame_ready}, 32'd0);
        check("flush_err_clr", {31'd0, bus.frame_err}, 32'd0);
        check("flush_keeps_count", {24'd0, bus.frames_loaded}, m_frames % 256);
        @(posedge clk);
        #1;
    endtask

    // Every write strobe is compared against the model's expected address/data.
    always @(negedge clk) begin
        if (rst_n && bus.mem_write) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {27'd0, bus.mem_waddr}, 32'hFFFF_FFFF);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("wr_addr", {27'd0, bus.mem_waddr}, {27'd0, w.a});
                check("wr_data", {4'd0, bus.mem_wdata}, {4'd0, w.d});
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [27:0] d;
        logic [13:0] kk;

        vecs[0] = '{din:{14'h0000, 14'h0000}, last:1'b0, addr:5'd0,  dout:{14'h0000, 14'h0000}};
        vecs[1] = '{din:{14'h0001, 14'h0001}, last:1'b0, addr:5'd16, dout:{14'h0001, 14'h3FFF}};
        vecs[2] = '{din:{14'h1ABC, 14'h2000}, last:1'b0, addr:5'd8,  dout:{14'h1ABC, 14'h1FFF}};
        vecs[3] = '{din:{14'h2000, 14'h1FFF}, last:1'b0, addr:5'd24, dout:{14'h2000, 14'h2001}};
        vecs[4] = '{din:{14'h3FFF, 14'h3FFF}, last:1'b0, addr:5'd4,  dout:{14'h3FFF, 14'h0001}};
        vecs[5] = '{din:{14'h0123, 14'h0005}, last:1'b0, addr:5'd20, dout:{14'h0123, 14'h3FFB}};
        vecs[6] = '{din:{14'h0000, 14'h2001}, last:1'b0, addr:5'd12, dout:{14'h0000, 14'h1FFF}};
        vecs[7] = '{din:{14'h1FFF, 14'h0000}, last:1'b0, addr:5'd28, dout:{14'h1FFF, 14'h0000}};

        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
        bus.in_last = 1'b0; bus.frame_taken = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_mem_write", {31'd0, bus.mem_write}, 32'd0);
        check("rst_waddr", {27'd0, bus.mem_waddr}, 32'd0);
        check("rst_wdata", {4'd0, bus.mem_wdata}, 32'd0);
        check("rst_frame_ready", {31'd0, bus.frame_ready}, 32'd0);
        check("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
        check("rst_frames_loaded", {24'd0, bus.frames_loaded}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("in_ready_before_edge", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk);
        #1 check("in_ready_after_edge", {31'd0, bus.in_ready}, 32'd1);

        // Table vectors: first eight samples of frame 1
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].din, vecs[i].last);
            @(negedge clk);
            check($sformatf("vec%0d_write", i), {31'd0, bus.mem_write}, 32'd1);
            check($sformatf("vec%0d_addr", i), {27'd0, bus.mem_waddr}, {27'd0, vecs[i].addr});
            check($sformatf("vec%0d_data", i), {4'd0, bus.mem_wdata}, {4'd0, vecs[i].dout});
            @(posedge clk);
            #1;
        end
        for (int k = 8; k < 32; k++) begin
            kk = 14'(k);
            send({kk, kk}, k == 31);
        end
        @(negedge clk);
        check("drain_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("drain_ready_n1", {31'd0, bus.frame_ready}, 32'd0);
        @(negedge clk);
        check("drain_ready_n2", {31'd0, bus.frame_ready}, 32'd0);
        @(negedge clk);
        check("frame1_ready", {31'd0, bus.frame_ready}, 32'd1);
        check("frame1_loaded", {24'd0, bus.frames_loaded}, 32'd1);
        check("frame1_err", {31'd0, bus.frame_err}, 32'd0);
        check("frame1_all_written", exp_q.size(), 32'd0);

        // Backpressure while FULL
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_data  = 28'h0ABCDEF;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check("bp_no_write", {31'd0, bus.mem_write}, 32'd0);
            @(posedge clk);
            #1;
        end
        bus.in_valid    = 1'b0;
        bus.frame_taken = 1'b1;
        @(negedge clk);
        check("taken_ready_still", {31'd0, bus.frame_ready}, 32'd1);
        @(posedge clk);
        #1 bus.frame_taken = 1'b0;
        @(negedge clk);
        check("taken_ready_clr", {31'd0, bus.frame_ready}, 32'd0);
        check("taken_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        send(28'h0012345, 1'b0);
        @(negedge clk);
        check("after_take_addr0", {27'd0, bus.mem_waddr}, 32'd0);
        @(posedge clk);
        #1;

        // Early in_last at index 9
        for (int k = 1; k < 10; k++) send(28'($urandom()), k == 9);
        @(negedge clk);
        check("early_last_err", {31'd0, bus.frame_err}, 32'd1);
        @(posedge clk);
        #1;
        send(28'($urandom()), 1'b0);
        @(negedge clk);
        check("early_restart_addr0", {27'd0, bus.mem_waddr}, 32'd0);
        @(posedge clk);
        #1;
        for (int k = 1; k < 31; k++) send(28'($urandom()), 1'b0);
        @(negedge clk);
        check("early_not_ready_at31", {31'd0, bus.frame_ready}, 32'd0);
        check("early_err_sticky", {31'd0, bus.frame_err}, 32'd1);
        @(posedge clk);
        #1;
        send(28'($urandom()), 1'b1);
        wait_frame();
        check("early_loaded", {24'd0, bus.frames_loaded}, 32'd2);
        take();

        // Missing in_last at index 31, then flush in FULL
        pulse_flush();
        for (int k = 0; k < 32; k++) send(28'($urandom()), 1'b0);
        wait_frame();
        check("missing_last_err", {31'd0, bus.frame_err}, 32'd1);
        check("missing_last_loaded", {24'd0, bus.frames_loaded}, 32'd3);
        @(posedge clk);
        #1;
        pulse_flush();
        check("flush_full_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Async reset mid-frame at index 12
        for (int k = 0; k < 12; k++) send(28'($urandom()) | 28'h0004000, 1'b0);
        check("pre_rst_write", {31'd0, bus.mem_write}, 32'd1);
        #1 rst_n = 1'b0;
        void'(exp_q.pop_back());
        m_idx = 0; m_err = 0; m_frames = 0;
        #1;
        check("arst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("arst_mem_write", {31'd0, bus.mem_write}, 32'd0);
        check("arst_waddr", {27'd0, bus.mem_waddr}, 32'd0);
        check("arst_wdata", {4'd0, bus.mem_wdata}, 32'd0);
        check("arst_loaded", {24'd0, bus.frames_loaded}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 32; k++) send(28'($urandom()), k == 31);
        wait_frame();
        check("post_rst_loaded", {24'd0, bus.frames_loaded}, 32'd1);
        check("post_rst_err", {31'd0, bus.frame_err}, 32'd0);
        take();

        // Random frames with idle gaps, running the frame counter through its wrap
        for (int f = 0; f < 255; f++) begin
            for (int k = 0; k < 32; k++) begin
                if ($urandom_range(0, 7) == 0) begin
                    @(posedge clk);
                    #1;
                end
                d = 28'($urandom());
                if ($urandom_range(0, 15) == 0) d[13:0] = 14'h2000;
                send(d, k == 31);
            end
            wait_frame();
            check("rand_loaded", {24'd0, bus.frames_loaded}, m_frames % 256);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            take();
        end
        check("loaded_wrapped", {24'd0, bus.frames_loaded}, 32'd0);
        @(negedge clk);
        check("no_pending_writes", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
